// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mult_pkg
//  Purpose  : Shared definitions for the shift-and-add multiplier: FSM state
//             encoding and the iteration-counter width helper.
//  Contents : state_t (S_IDLE/S_RUN/S_DONE), cnt_w(n) = $clog2(n+1)
//  Revision : 1.0 - initial release
// ============================================================================
package mult_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // The counter must be able to hold N itself (it increments once more on
    // the final RUN cycle), hence N+1 distinct values.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage : mult_pkg
`default_nettype wire

// File: rtl/carry_look_ahead_adder.sv
`default_nettype none
// ============================================================================
//  Module   : carry_look_ahead_adder
//  Purpose  : N-bit carry-look-ahead adder, S = A + B + C_in.
//  Ports    : A, B   in  [N-1:0]  addends
//             C_in   in  1        carry in
//             S      out [N-1:0]  sum
//             C_out  out 1        carry out
//  Revision : 1.0 - initial release
// ============================================================================
module carry_look_ahead_adder #(
    parameter int N = 8
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         C_in,
    output logic [N-1:0] S,
    output logic         C_out
);

    logic [N-1:0] w_g;
    logic [N-1:0] w_p;
    logic [N:0]   w_c;
    logic         w_term;
    logic         w_pchain;

    assign w_g = A & B;
    assign w_p = A ^ B;

    // Every carry is expanded directly from generate/propagate terms:
    // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]C_in, with no ripple dependency.
    always_comb begin
        w_c      = '0;
        w_term   = 1'b0;
        w_pchain = 1'b0;
        w_c[0]   = C_in;
        for (int i = 0; i < N; i++) begin
            w_term   = w_g[i];
            w_pchain = w_p[i];
            for (int j = i - 1; j >= 0; j--) begin
                w_term   = w_term | (w_pchain & w_g[j]);
                w_pchain = w_pchain & w_p[j];
            end
            w_c[i+1] = w_term | (w_pchain & C_in);
        end
    end

    assign S     = w_p ^ w_c[N-1:0];
    assign C_out = w_c[N];

endmodule : carry_look_ahead_adder
`default_nettype wire

// File: rtl/mult_shift_add_cla.sv
`default_nettype none
// ============================================================================
//  Module   : mult_shift_add_cla
//  Purpose  : Sequential unsigned N x N radix-2 shift-and-add multiplier, one
//             partial product per clock through a carry-look-ahead adder.
//  Ports    : clk      in   1     clock, rising edge
//             rst      in   1     asynchronous reset, active-high
//             start    in   1     request, sampled only in IDLE
//             a, b     in   N     multiplicand / multiplier, latched on accept
//             ready    out  1     IDLE (start will be accepted)
//             busy     out  1     RUN
//             done     out  1     one-cycle pulse, product valid from here on
//             product  out  2N    a*b, held until the next accepted start
//  Config   : MULT_ZERO_SKIP_EN - when defined, a zero operand completes
//             IDLE -> DONE directly with product 0 and no RUN cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module mult_shift_add_cla
    import mult_pkg::*;
#(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           ready,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int               CNT_W  = cnt_w(N);
    localparam logic [CNT_W-1:0] c_last = CNT_W'(N - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [N-1:0]       r_mcand;
    logic [N-1:0]       r_acc_hi;
    logic [N-1:0]       r_acc_lo;
    logic [CNT_W-1:0]   r_count;
    logic [2*N-1:0]     r_product;

    logic [N-1:0]       w_addend;
    logic [N-1:0]       w_sum;
    logic               w_cout;
    logic [2*N-1:0]     w_next_acc;
    logic               w_accept;
    logic               w_zero;
    logic               w_last;

`ifdef MULT_ZERO_SKIP_EN
    assign w_zero = (a == '0) || (b == '0);
`else
    assign w_zero = 1'b0;
`endif

    assign w_accept = (r_state == S_IDLE) && start;
    assign w_last   = (r_count == c_last);
    assign w_addend = r_acc_lo[0] ? r_mcand : '0;

    carry_look_ahead_adder #(.N(N)) u_adder (
        .A     (r_acc_hi),
        .B     (w_addend),
        .C_in  (1'b0),
        .S     (w_sum),
        .C_out (w_cout)
    );

    // The carry-out becomes the new MSB as the accumulator shifts right, so
    // the 2N-bit accumulator never loses a bit.
    assign w_next_acc = {w_cout, w_sum, r_acc_lo[N-1:1]};

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start)  w_state_next = w_zero ? S_DONE : S_RUN;
            S_RUN:   if (w_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mcand   <= '0;
            r_acc_hi  <= '0;
            r_acc_lo  <= '0;
            r_count   <= '0;
            r_product <= '0;
        end else if (w_accept) begin
            r_mcand  <= a;
            r_acc_hi <= '0;
            r_acc_lo <= b;
            r_count  <= '0;
            // Only the zero-skip path touches the product at accept time.
            if (w_zero) begin
                r_product <= '0;
            end
        end else if (r_state == S_RUN) begin
            {r_acc_hi, r_acc_lo} <= w_next_acc;
            r_count              <= r_count + CNT_W'(1);
            if (w_last) begin
                r_product <= w_next_acc;
            end
        end
    end

    assign ready   = (r_state == S_IDLE);
    assign busy    = (r_state == S_RUN);
    assign done    = (r_state == S_DONE);
    assign product = r_product;

endmodule : mult_shift_add_cla
`default_nettype wire

// File: tb/tb_mult_shift_add_cla.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mult_shift_add_cla
//  Purpose  : Self-checking bench for mult_shift_add_cla: directed N=8 cases
//             (basic, all-ones, ignored start, mid-run reset, zero operand)
//             and 1000 randomized N=16 operations against a*b.
//  Config   : MULT_ZERO_SKIP_EN changes expected latency for zero operands.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mult_shift_add_cla;

`ifdef MULT_ZERO_SKIP_EN
    localparam bit ZSKIP = 1'b1;
`else
    localparam bit ZSKIP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;

    logic        start8;
    logic [7:0]  a8, b8;
    logic        ready8, busy8, done8;
    logic [15:0] product8;

    logic        start16;
    logic [15:0] a16, b16;
    logic        ready16, busy16, done16;
    logic [31:0] product16;

    bit          sel16 = 1'b0;
    logic        obs_ready, obs_busy, obs_done;
    logic [31:0] obs_product;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    mult_shift_add_cla #(.N(8)) u_dut8 (
        .clk     (clk),
        .rst     (rst),
        .start   (start8),
        .a       (a8),
        .b       (b8),
        .ready   (ready8),
        .busy    (busy8),
        .done    (done8),
        .product (product8)
    );

    mult_shift_add_cla #(.N(16)) u_dut16 (
        .clk     (clk),
        .rst     (rst),
        .start   (start16),
        .a       (a16),
        .b       (b16),
        .ready   (ready16),
        .busy    (busy16),
        .done    (done16),
        .product (product16)
    );

    assign obs_ready   = sel16 ? ready16   : ready8;
    assign obs_busy    = sel16 ? busy16    : busy8;
    assign obs_done    = sel16 ? done16    : done8;
    assign obs_product = sel16 ? product16 : {16'h0, product8};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic s, input logic [15:0] a, input logic [15:0] b);
        if (sel16) begin
            start16 = s; a16 = a; b16 = b;
        end else begin
            start8 = s; a8 = a[7:0]; b8 = b[7:0];
        end
    endtask

    // One full operation on the selected DUT. With hold set, start stays
    // high (with different operands) until done, and must be ignored.
    task automatic do_op(input logic [15:0] a_in, input logic [15:0] b_in,
                         input bit hold, input string tag);
        int          n;
        int          lat;
        int          busy_cnt;
        int          exp_lat;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] exp;
        n        = sel16 ? 16 : 8;
        a        = sel16 ? a_in : {8'h0, a_in[7:0]};
        b        = sel16 ? b_in : {8'h0, b_in[7:0]};
        exp      = 32'(a) * 32'(b);
        exp_lat  = (ZSKIP && (a == 0 || b == 0)) ? 0 : n;
        lat      = 0;
        busy_cnt = 0;
        @(negedge clk);
        set_in(1'b1, a, b);
        @(posedge clk); #1;
        if (hold) set_in(1'b1, ~a, b + 16'd3);
        else      set_in(1'b0, ~a, ~b);
        forever begin
            check({tag, " onehot"}, 32'($countones({obs_ready, obs_busy, obs_done})), 32'd1);
            if (obs_done) break;
            if (lat > n + 4) break;
            if (obs_busy) busy_cnt++;
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " busy_cycles"}, 32'(busy_cnt), 32'(exp_lat));
        check({tag, " product"}, obs_product, exp);
        if (hold) set_in(1'b0, 16'h0, 16'h0);
        @(posedge clk); #1;
        check({tag, " ready_after"}, {31'h0, obs_ready}, 32'd1);
        check({tag, " done_after"}, {31'h0, obs_done}, 32'd0);
        check({tag, " product_held"}, obs_product, exp);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          pulses;
        logic [15:0] ra, rb;
        rst = 1'b1;
        start8 = 1'b0;  a8 = '0;  b8 = '0;
        start16 = 1'b0; a16 = '0; b16 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst ready8",    {31'h0, ready8},   32'd1);
        check("rst busy8",     {31'h0, busy8},    32'd0);
        check("rst done8",     {31'h0, done8},    32'd0);
        check("rst product8",  {16'h0, product8}, 32'd0);
        check("rst ready16",   {31'h0, ready16},  32'd1);
        check("rst busy16",    {31'h0, busy16},   32'd0);
        check("rst done16",    {31'h0, done16},   32'd0);
        check("rst product16", product16,         32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed N=8 cases
        sel16 = 1'b0;
        do_op(16'd13, 16'd11, 1'b0, "m13x11");
        check("m13x11 const", obs_product, 32'd143);
        do_op(16'hFF, 16'hFF, 1'b0, "mFFxFF");
        check("mFFxFF const", obs_product, 32'hFE01);
        do_op(16'd7, 16'd9, 1'b1, "start_held");

        // Reset in the middle of RUN aborts the operation
        @(negedge clk);
        set_in(1'b1, 16'd13, 16'd11);
        @(posedge clk); #1;
        set_in(1'b0, 16'd0, 16'd0);
        repeat (4) @(posedge clk);
        #1;
        check("midrst busy_before", {31'h0, obs_busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("midrst ready",   {31'h0, obs_ready}, 32'd1);
        check("midrst busy",    {31'h0, obs_busy},  32'd0);
        check("midrst done",    {31'h0, obs_done},  32'd0);
        check("midrst product", obs_product,        32'd0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (obs_done) pulses++;
        end
        check("midrst no_done", 32'(pulses), 32'd0);
        do_op(16'd13, 16'd11, 1'b0, "after_rst");
        do_op(16'd0, 16'h5A, 1'b0, "zero_a");
        do_op(16'h5A, 16'd0, 1'b0, "zero_b");

        // Randomized N=16 against the a*b model
        sel16 = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (i == 0) begin ra = 16'hFFFF; rb = 16'hFFFF; end
            if (i == 1) ra = 16'h0;
            if (i == 2) rb = 16'h0;
            if ($urandom_range(0, 31) == 0) ra = 16'h0;
            do_op(ra, rb, 1'b0, "rand16");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_mult_shift_add_cla
`default_nettype wire
